// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALUOp and WDSel codes plus forwarding selects.
package id_ex_stage_pkg;

  localparam logic [4:0] ALUOp_nop   = 5'b00000;
  localparam logic [4:0] ALUOp_lui   = 5'b00001;
  localparam logic [4:0] ALUOp_auipc = 5'b00010;
  localparam logic [4:0] ALUOp_add   = 5'b00011;
  localparam logic [4:0] ALUOp_sub   = 5'b00100;
  localparam logic [4:0] ALUOp_and   = 5'b00101;
  localparam logic [4:0] ALUOp_or    = 5'b00110;
  localparam logic [4:0] ALUOp_xor   = 5'b00111;

  localparam logic [1:0] WDSel_FromALU = 2'b00;
  localparam logic [1:0] WDSel_FromMEM = 2'b01;
  localparam logic [1:0] WDSel_FromPC  = 2'b10;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Bypass source select for one EX-stage source register; the younger EX/MEM result wins.
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int RWIDTH = 5
) (
  input  logic [RWIDTH-1:0] rs,
  input  logic [RWIDTH-1:0] exm_rd,
  input  logic              exm_regwrite,
  input  logic [RWIDTH-1:0] wb_rd,
  input  logic              wb_regwrite,
  output fwd_sel_e          sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs != '0) begin
      if (exm_regwrite && (exm_rd == rs))    sel = FWD_EXM;
      else if (wb_regwrite && (wb_rd == rs)) sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and operand bypassing.
// Optional performance counters are built when IDEX_PERF_CNT_EN is defined.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RWIDTH-1:0] id_rs1,
  input  logic [RWIDTH-1:0] id_rs2,
  input  logic [RWIDTH-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_aluop,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic [1:0]        id_wdsel,
  input  logic              flush_i,
  input  logic [RWIDTH-1:0] exm_rd,
  input  logic              exm_regwrite,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [RWIDTH-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [4:0]        alu_op,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [RWIDTH-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [1:0]        ex_wdsel,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [RWIDTH-1:0] rs1;
    logic [RWIDTH-1:0] rs2;
    logic [RWIDTH-1:0] rd;
    logic [4:0]        aluop;
    logic              alusrc;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [1:0]        wdsel;
  } id_ex_t;

  id_ex_t   ex_q;
  id_ex_t   ex_d;
  logic     hz;
  fwd_sel_e sel1, sel2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  assign hz = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid &&
              ((id_use_rs1 && (id_rs1 == ex_q.rd)) || (id_use_rs2 && (id_rs2 == ex_q.rd)));
  assign stall_o = hz && !flush_i;

  // Controls are qualified by id_valid so an empty EX slot never writes anything.
  always_comb begin
    ex_d          = '0;
    ex_d.valid    = id_valid;
    ex_d.pc       = id_pc;
    ex_d.rs1_data = id_rs1_data;
    ex_d.rs2_data = id_rs2_data;
    ex_d.imm      = id_imm;
    ex_d.rs1      = id_rs1;
    ex_d.rs2      = id_rs2;
    ex_d.rd       = id_rd;
    ex_d.alusrc   = id_alusrc;
    ex_d.wdsel    = id_wdsel;
    if (id_valid) begin
      ex_d.aluop    = id_aluop;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.memwrite = id_memwrite;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                ex_q <= '0;
    else if (flush_i || hz) ex_q <= '0;
    else                    ex_q <= ex_d;
  end

  fwd_unit #(.RWIDTH(RWIDTH)) u_fwd_rs1 (
    .rs(ex_q.rs1), .exm_rd(exm_rd), .exm_regwrite(exm_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel1)
  );

  fwd_unit #(.RWIDTH(RWIDTH)) u_fwd_rs2 (
    .rs(ex_q.rs2), .exm_rd(exm_rd), .exm_regwrite(exm_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel2)
  );

  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    case (sel1)
      FWD_EXM: fwd_rs1 = exm_result;
      FWD_WB:  fwd_rs1 = wb_data;
      default: fwd_rs1 = ex_q.rs1_data;
    endcase
    fwd_rs2 = ex_q.rs2_data;
    case (sel2)
      FWD_EXM: fwd_rs2 = exm_result;
      FWD_WB:  fwd_rs2 = wb_data;
      default: fwd_rs2 = ex_q.rs2_data;
    endcase
  end

  assign ex_valid      = ex_q.valid;
  assign alu_a         = fwd_rs1;
  assign alu_b         = ex_q.alusrc ? ex_q.imm : fwd_rs2;
  assign alu_op        = ex_q.aluop;
  assign ex_pc         = ex_q.pc;
  assign ex_store_data = fwd_rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_wdsel      = ex_q.wdsel;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_o) stall_q <= stall_q + 32'd1;
      if (flush_i) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX-slot contents are queued at drive time
// and popped after the capturing edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic [4:0]  id_aluop;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite;
  logic [1:0]  id_wdsel;
  logic        flush_i;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_regwrite, wb_regwrite;
  logic [31:0] exm_result, wb_data;
  logic        stall_o, ex_valid;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [4:0]  alu_op, ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;
  logic [1:0]  ex_wdsel;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] a, b, pc, sd;
    logic [4:0]  op, rd;
    logic        rw, mr, mw;
    logic [1:0]  wd;
  } exp_t;

  exp_t sb[$];

`ifdef IDEX_PERF_CNT_EN
  localparam logic [31:0] PERF_ONE = 32'd1;
`else
  localparam logic [31:0] PERF_ONE = 32'd0;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_wdsel(id_wdsel), .flush_i(flush_i),
    .exm_rd(exm_rd), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .stall_o(stall_o), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_wdsel(ex_wdsel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic [4:0] op, input logic src,
                        input logic rw, input logic mr, input logic mw, input logic [1:0] wd);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2;
    id_rs2_data = d2; id_imm = imm; id_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
    id_aluop = op; id_alusrc = src; id_regwrite = rw; id_memread = mr;
    id_memwrite = mw; id_wdsel = wd;
  endtask

  task automatic push(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] sd, input logic [4:0] op,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                      input logic [1:0] wd);
    exp_t e;
    e.valid = v; e.a = a; e.b = b; e.pc = pc; e.sd = sd; e.op = op;
    e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw; e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
    chk({tag, ".alu_a"}, alu_a, e.a);
    chk({tag, ".alu_b"}, alu_b, e.b);
    chk({tag, ".ex_pc"}, ex_pc, e.pc);
    chk({tag, ".store_data"}, ex_store_data, e.sd);
    chk({tag, ".alu_op"}, {27'd0, alu_op}, {27'd0, e.op});
    chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
    chk({tag, ".ctrl"}, {29'd0, ex_regwrite, ex_memread, ex_memwrite}, {29'd0, e.rw, e.mr, e.mw});
    chk({tag, ".wdsel"}, {30'd0, ex_wdsel}, {30'd0, e.wd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0;
    exm_rd = '0; exm_regwrite = 1'b0; exm_result = '0;
    wb_rd = '0; wb_regwrite = 1'b0; wb_data = '0;
    set_id(1, 32'h40, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd4, 1, 1, ALUOp_add, 0, 1, 0, 0, WDSel_FromALU);

    // Reset held two cycles with a valid ID instruction present
    tick(); tick();
    chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.ex_regwrite", {31'd0, ex_regwrite}, 32'd0);
    chk("rst.alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst.stall_o", {31'd0, stall_o}, 32'd0);
    chk("rst.ex_pc", ex_pc, 32'd0);
    chk("rst.stall_cnt", stall_cnt, 32'd0);
    chk("rst.flush_cnt", flush_cnt, 32'd0);
    rst = 1'b0;

    // EX/MEM forward into rs1
    set_id(1, 32'h100, 5'd5, 32'h99, 5'd6, 32'h66, 32'h0, 5'd8, 1, 1, ALUOp_add, 0, 1, 0, 0, WDSel_FromALU);
    exm_rd = 5'd5; exm_regwrite = 1'b1; exm_result = 32'h10;
    push(1, 32'h10, 32'h66, 32'h100, 32'h66, ALUOp_add, 5'd8, 1, 0, 0, WDSel_FromALU);
    #1 chk("exm.stall_o", {31'd0, stall_o}, 32'd0);
    tick();
    pop_chk("exm");

    // EX/MEM beats MEM/WB on rs2; then MEM/WB alone
    set_id(1, 32'h104, 5'd1, 32'h11, 5'd7, 32'h77, 32'h0, 5'd9, 1, 1, ALUOp_sub, 0, 1, 0, 0, WDSel_FromALU);
    exm_rd = 5'd7; exm_regwrite = 1'b1; exm_result = 32'h1;
    wb_rd = 5'd7; wb_regwrite = 1'b1; wb_data = 32'h2;
    push(1, 32'h11, 32'h1, 32'h104, 32'h1, ALUOp_sub, 5'd9, 1, 0, 0, WDSel_FromALU);
    tick();
    pop_chk("prio");
    exm_regwrite = 1'b0;
    #1;
    chk("wbonly.alu_b", alu_b, 32'h2);
    chk("wbonly.store_data", ex_store_data, 32'h2);

    // x0 is never bypassed; immediate selects B
    set_id(1, 32'h108, 5'd0, 32'h0, 5'd0, 32'h0, 32'hFFFF_FFF0, 5'd10, 1, 1, ALUOp_add, 1, 1, 0, 0, WDSel_FromALU);
    exm_rd = 5'd0; exm_regwrite = 1'b1; exm_result = 32'hDEAD;
    wb_rd = 5'd0; wb_regwrite = 1'b1; wb_data = 32'hBEEF;
    push(1, 32'h0, 32'hFFFF_FFF0, 32'h108, 32'h0, ALUOp_add, 5'd10, 1, 0, 0, WDSel_FromALU);
    tick();
    pop_chk("x0");

    // Load-use: lw x3 then add reading x3
    exm_regwrite = 1'b0; wb_regwrite = 1'b0;
    set_id(1, 32'h10C, 5'd2, 32'h200, 5'd0, 32'h0, 32'h4, 5'd3, 1, 0, ALUOp_add, 1, 1, 1, 0, WDSel_FromMEM);
    push(1, 32'h200, 32'h4, 32'h10C, 32'h0, ALUOp_add, 5'd3, 1, 1, 0, WDSel_FromMEM);
    tick();
    pop_chk("lw");
    set_id(1, 32'h110, 5'd3, 32'h33, 5'd4, 32'h44, 32'h0, 5'd11, 1, 1, ALUOp_add, 0, 1, 0, 0, WDSel_FromALU);
    #1 chk("lu.stall_o", {31'd0, stall_o}, 32'd1);
    push(0, 32'h0, 32'h0, 32'h0, 32'h0, ALUOp_nop, 5'd0, 0, 0, 0, 2'd0);
    tick();
    pop_chk("lu.bubble");
    chk("lu.stall_released", {31'd0, stall_o}, 32'd0);
    wb_rd = 5'd3; wb_regwrite = 1'b1; wb_data = 32'h5A5A;
    push(1, 32'h5A5A, 32'h44, 32'h110, 32'h44, ALUOp_add, 5'd11, 1, 0, 0, WDSel_FromALU);
    tick();
    pop_chk("lu.add");
    chk("lu.stall_cnt", stall_cnt, PERF_ONE);

    // Fresh reset, then flush coinciding with a load-use hazard
    rst = 1'b1; id_valid = 1'b0; wb_regwrite = 1'b0;
    tick(); tick();
    rst = 1'b0;
    set_id(1, 32'h114, 5'd2, 32'h200, 5'd0, 32'h0, 32'h4, 5'd3, 1, 0, ALUOp_add, 1, 1, 1, 0, WDSel_FromMEM);
    push(1, 32'h200, 32'h4, 32'h114, 32'h0, ALUOp_add, 5'd3, 1, 1, 0, WDSel_FromMEM);
    tick();
    pop_chk("fl.lw");
    set_id(1, 32'h118, 5'd3, 32'h33, 5'd4, 32'h44, 32'h0, 5'd12, 1, 1, ALUOp_add, 0, 1, 0, 0, WDSel_FromALU);
    flush_i = 1'b1;
    #1 chk("fl.stall_o", {31'd0, stall_o}, 32'd0);
    push(0, 32'h0, 32'h0, 32'h0, 32'h0, ALUOp_nop, 5'd0, 0, 0, 0, 2'd0);
    tick();
    flush_i = 1'b0;
    pop_chk("fl.bubble");
    chk("fl.flush_cnt", flush_cnt, PERF_ONE);
    chk("fl.stall_cnt", stall_cnt, 32'd0);

    // Reset arriving during a stall clears the EX slot
    set_id(1, 32'h11C, 5'd2, 32'h200, 5'd0, 32'h0, 32'h4, 5'd3, 1, 0, ALUOp_add, 1, 1, 1, 0, WDSel_FromMEM);
    tick();
    set_id(1, 32'h120, 5'd3, 32'h33, 5'd4, 32'h44, 32'h0, 5'd13, 1, 1, ALUOp_add, 0, 1, 0, 0, WDSel_FromALU);
    #1 chk("rs.stall_o_before", {31'd0, stall_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs.stall_o_after", {31'd0, stall_o}, 32'd0);
    chk("rs.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rs.ex_memread", {31'd0, ex_memread}, 32'd0);
    chk("rs.flush_cnt", flush_cnt, 32'd0);
    chk("rs.queue_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding front end for the EX-stage alu.
- Captures decoded operands and control from ID and detects load-use hazards; inserts bubbles on stall or flush.
- Drives alu inputs A, B, ALUOp and PC, with EX/MEM and MEM/WB bypassing resolved in front of the alu.

Parameters:
- XLEN, 32, datapath width
- RWIDTH, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  RWIDTH  register indices
- id_use_rs1, id_use_rs2  in  1  instruction reads rs1/rs2
- id_aluop  in  5  ALUOp code from ctrl_encode_def.v
- id_alusrc  in  1  1: B = immediate
- id_regwrite, id_memread, id_memwrite  in  1  control
- id_wdsel  in  2  writeback select code
- flush_i  in  1  branch/jump redirect; kills ID instruction
- exm_rd  in  RWIDTH  EX/MEM destination
- exm_regwrite  in  1  EX/MEM writes rd
- exm_result  in  XLEN  EX/MEM alu result
- wb_rd  in  RWIDTH  MEM/WB destination
- wb_regwrite  in  1  MEM/WB writes rd
- wb_data  in  XLEN  MEM/WB writeback data
- stall_o  out  1  hold PC and IF/ID
- ex_valid  out  1  EX slot valid
- alu_a, alu_b  out  XLEN  alu operands
- alu_op  out  5  alu ALUOp
- ex_pc  out  XLEN  PC to alu / EX/MEM
- ex_store_data  out  XLEN  forwarded rs2 for stores
- ex_rd  out  RWIDTH
- ex_regwrite, ex_memread, ex_memwrite  out  1
- ex_wdsel  out  2
- stall_cnt, flush_cnt  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at posedge): all registered state is 0, so ex_valid=0, control=0, alu_op=0 (ALUOp_nop), ex_pc=0, ex_rd=0.
- Hazard: hz = ex_valid & ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) & id_valid.
- stall_o = hz & ~flush_i (combinational).
- Register update at each posedge, in priority order:
  - rst: reset values.
  - flush_i: bubble.
  - hz: bubble.
  - otherwise: capture all id_* fields; ex_valid=id_valid.
- Bubble: ex_valid=0, regwrite/memread/memwrite=0, alu_op=ALUOp_nop; data fields don't-care but held at 0.
- ex_valid=0 always implies all three write/read controls are 0. Bubble latency is 1 cycle; a load-use stall lasts exactly 1 cycle.
- Forwarding (combinational on registered rs1/rs2):
  - rs==0: register-file value.
  - else if exm_regwrite & exm_rd==rs: exm_result.
  - else if wb_regwrite & wb_rd==rs: wb_data.
  - else: registered read data. EX/MEM wins over MEM/WB.
- alu_a = fwd_rs1.
- alu_b = ex_alusrc ? ex_imm : fwd_rs2.
- ex_store_data = fwd_rs2 regardless of alusrc.
- auipc/lui rely on alu's PC and B inputs; no special casing here.
- The register file is write-first; this block performs no ID-stage bypass.
- flush_i and hz in the same cycle: flush wins, stall_o=0.
- rst asserted mid-stall: state cleared; stall_o drops because ex_valid=0.

Optional Feature:
- IDEX_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle with stall_o=1.
  - flush_cnt increments on every cycle with flush_i=1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- Shared package / ctrl_encode_def.v: ALUOp_* codes, WDSel codes, new forwarding-select constants FWD_RF=2'b00, FWD_EXM=2'b01, FWD_WB=2'b10.
- One sub-module: fwd_unit, combinational. Inputs: rs, exm/wb rd and regwrite. Output: 2-bit select. Instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, ex_regwrite=0, alu_op=0, stall_o=0.
- EX/MEM forward: x5 written by the prior add (exm_rd=5, exm_result=0x10); current add reads rs1=5, rs1_data=0x99 -> alu_a=0x10.
- Priority: exm_rd=wb_rd=7, exm_result=1, wb_data=2, rs2=7, alusrc=0 -> alu_b=1, ex_store_data=1.
- x0 guard: exm_rd=0, exm_regwrite=1, rs1=0, rs1_data=0 -> alu_a=0.
- Load-use: lw x3 in EX, ID add rs1=3 -> stall_o=1 for one cycle; next cycle ex_valid=0; following cycle add enters with ex_valid=1.
- Flush vs hazard: same setup plus flush_i=1 -> stall_o=0; next cycle ex_valid=0. With IDEX_PERF_CNT_EN: flush_cnt=1, stall_cnt=0.
